// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the 7-segment scan driver.
// Patterns are active-high gfedcba; pin polarity is applied in the top level.
package seg7_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    pat = SEG_OFF;
    unique case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high gfedcba segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver running on the board clock; scan_clk is
// synchronized and edge-detected as data, never used as a clock.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          AN_ACT_LOW   = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel
);

  localparam logic [3:0] AN_IDLE    = AN_OFF ^ {4{AN_ACT_LOW}};
  localparam logic [6:0] SEG_IDLE   = SEG_OFF ^ {7{SEG_ACT_LOW}};
  localparam logic       DP_IDLE    = SEG_ACT_LOW;
  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

  logic        sync1, sync2, sync3, scan_tick;
  logic [7:0]  blank_cnt;
  logic [15:0] shadow_val, live_val;
  logic [3:0]  shadow_dp, live_dp;

  logic        wrap;
  logic [1:0]  sel_next, sel_d;
  logic [15:0] live_val_d;
  logic [3:0]  live_dp_d;
  logic [3:0]  nibble;
  logic [6:0]  hex_pat, seg_pat;
  logic        lead_zero;
  logic [7:0]  cnt_d;
  logic [3:0]  an_d;

  assign wrap     = scan_tick && (digit_sel == LAST_DIGIT);
  assign sel_next = digit_sel + 2'd1;
  assign sel_d    = scan_tick ? sel_next : digit_sel;

  // Shadow is copied to live only on the frame wrap; a load on that same clock bypasses.
  assign live_val_d = wrap ? (load ? value : shadow_val) : live_val;
  assign live_dp_d  = wrap ? (load ? dp_in : shadow_dp) : live_dp;

  assign nibble    = live_val_d[{sel_next, 2'b00} +: 4];
  assign lead_zero = blank_lz && (sel_next != 2'd0) &&
                     ((live_val_d >> {sel_next, 2'b00}) == 16'h0000);

  seg7_hex_decode u_hex_decode (
    .nibble  (nibble),
    .pattern (hex_pat)
  );

  always_comb begin
    seg_pat = lead_zero ? SEG_OFF : hex_pat;
  end

  always_comb begin
    cnt_d = 8'd0;
    if (scan_tick) begin
      cnt_d = BLANK_LOAD;
    end else if (blank_cnt != 8'd0) begin
      cnt_d = blank_cnt - 8'd1;
    end
    an_d = AN_IDLE;
    if (cnt_d == 8'd0) begin
      an_d = (4'b0001 << sel_d) ^ {4{AN_ACT_LOW}};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      scan_tick  <= 1'b0;
      digit_sel  <= 2'd0;
      blank_cnt  <= 8'd0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      live_val   <= 16'h0000;
      live_dp    <= 4'h0;
      an         <= AN_IDLE;
      seg        <= SEG_IDLE;
      dp         <= DP_IDLE;
    end else begin
      sync1     <= scan_clk;
      sync2     <= sync1;
      sync3     <= sync2;
      scan_tick <= sync2 & ~sync3;
      digit_sel <= sel_d;
      blank_cnt <= cnt_d;
      an        <= an_d;
      live_val  <= live_val_d;
      live_dp   <= live_dp_d;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (scan_tick) begin
        seg <= seg_pat ^ {7{SEG_ACT_LOW}};
        dp  <= live_dp_d[sel_next] ^ SEG_ACT_LOW;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-clock comparison against a
// frame-level display model plus directed scenario checks.
module tb_seg7_scan_driver;

  localparam int B = 4;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        scan_clk = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  int checks = 0;
  int failures = 0;

  always #10 clock = ~clock;

  seg7_scan_driver #(
    .BLANK_CYCLES (B),
    .SEG_ACT_LOW  (1'b1),
    .AN_ACT_LOW   (1'b1)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .scan_clk  (scan_clk),
    .value     (value),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .load      (load),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  // scan_clk as seen by the design at each rising edge
  logic samp_edge = 1'b0;
  always @(posedge clock) samp_edge = scan_clk;

  always @(negedge clock) begin
    if (!clear) begin
      checks++;
      if (!$onehot0(~an)) begin
        failures++;
        $display("FAIL an_onehot t=%0t an=%b required at most one low bit", $time, an);
      end
    end
  end

  // Display model: what the panel should show, from sampled scan edges and load history.
  bit          hist[$];
  int          m_sel;
  int          m_since;
  logic [15:0] m_shadow, m_live;
  logic [3:0]  m_shdp, m_livedp;
  logic [6:0]  m_pat;
  logic        m_dpon;
  logic [6:0]  last_seg [4];

  function automatic void model_reset();
    hist = {1'b0, 1'b0, 1'b0, 1'b0};
    m_sel = 0;
    m_since = B;
    m_shadow = 16'h0000;
    m_live = 16'h0000;
    m_shdp = 4'h0;
    m_livedp = 4'h0;
    m_pat = 7'h00;
    m_dpon = 1'b0;
  endfunction

  function automatic logic [6:0] digit_pattern(logic [15:0] v, int d, logic blz);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (d > 0 && blz && upper == 16'h0000) return 7'h00;
    return HEX[upper[3:0]];
  endfunction

  // A scan edge first sampled at edge n-3 (previous sample low) advances the digit at edge n.
  function automatic void model_edge(bit s, logic ld, logic [15:0] v, logic [3:0] dpi,
                                     logic blz);
    bit adv;
    hist.push_back(s);
    if (hist.size() > 5) void'(hist.pop_front());
    adv = hist[1] && !hist[0];
    if (adv) begin
      if (m_sel == 3) begin
        m_live = ld ? v : m_shadow;
        m_livedp = ld ? dpi : m_shdp;
      end
      m_sel = (m_sel + 1) % 4;
      m_since = 0;
      m_pat = digit_pattern(m_live, m_sel, blz);
      m_dpon = m_livedp[m_sel];
    end else if (m_since < B) begin
      m_since++;
    end
    if (ld) begin
      m_shadow = v;
      m_shdp = dpi;
    end
  endfunction

  function automatic logic [13:0] model_pins();
    logic [3:0] a;
    a = (m_since >= B) ? ~(4'b0001 << m_sel) : 4'hF;
    return {a, ~m_pat, ~m_dpon, 2'(m_sel)};
  endfunction

  function automatic bit wrap_next();
    return hist[2] && !hist[1] && m_sel == 3;
  endfunction

  task automatic step();
    logic [13:0] exp;
    @(posedge clock);
    #1;
    if (clear) begin
      model_reset();
      exp = {4'hF, 7'h7F, 1'b1, 2'd0};
    end else begin
      model_edge(samp_edge, load, value, dp_in, blank_lz);
      exp = model_pins();
    end
    checks++;
    if ({an, seg, dp, digit_sel} !== exp) begin
      failures++;
      $display("FAIL pins t=%0t got an=%b seg=%h dp=%b sel=%0d required an=%b seg=%h dp=%b sel=%0d",
               $time, an, seg, dp, digit_sel, exp[13:10], exp[9:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic scan_edges(int edges, int half);
    for (int e = 0; e < edges; e++) begin
      for (int h = 0; h < 2; h++) begin
        scan_clk = (h == 0);
        for (int c = 0; c < half; c++) begin
          step();
          if (an != 4'hF) last_seg[digit_sel] = seg;
        end
      end
    end
  endtask

  task automatic test_reset();
    #3 clear = 1'b1;
    step();
    step();
    checks++;
    if ({an, seg, dp, digit_sel} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got an=%b seg=%h dp=%b sel=%0d required an=1111 seg=7f dp=1 sel=0",
               an, seg, dp, digit_sel);
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_scan_1234();
    value = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) last_seg[i] = 7'hxx;
    scan_edges(8, 8);
    checks++;
    if (last_seg[0] !== 7'h19) begin
      failures++;
      $display("FAIL scan_digit0 got seg=%h required 19", last_seg[0]);
    end
    checks++;
    if (last_seg[1] !== 7'h30) begin
      failures++;
      $display("FAIL scan_digit1 got seg=%h required 30", last_seg[1]);
    end
    checks++;
    if (last_seg[2] !== 7'h24) begin
      failures++;
      $display("FAIL scan_digit2 got seg=%h required 24", last_seg[2]);
    end
    checks++;
    if (last_seg[3] !== 7'h79) begin
      failures++;
      $display("FAIL scan_digit3 got seg=%h required 79", last_seg[3]);
    end
  endtask

  task automatic test_latency();
    int sel_at, an_at;
    logic [1:0] old_sel;
    scan_clk = 1'b0;
    for (int i = 0; i < 12; i++) step();
    old_sel = digit_sel;
    sel_at = -1;
    an_at = -1;
    scan_clk = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (sel_at < 0 && digit_sel != old_sel) sel_at = n;
      if (sel_at >= 0 && an_at < 0 && an != 4'hF) an_at = n;
    end
    scan_clk = 1'b0;
    checks++;
    if (sel_at != 4) begin
      failures++;
      $display("FAIL latency_sel got %0d clocks required 4", sel_at);
    end
    checks++;
    if (an_at != 4 + B) begin
      failures++;
      $display("FAIL latency_an got %0d clocks required %0d", an_at, 4 + B);
    end
    checks++;
    if (an_at - sel_at != B) begin
      failures++;
      $display("FAIL blank_window got %0d clocks required %0d", an_at - sel_at, B);
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] req [4];
    blank_lz = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      value = (pass == 0) ? 16'h0050 : 16'h0000;
      req[0] = 7'h40;
      req[1] = (pass == 0) ? 7'h12 : 7'h7F;
      req[2] = 7'h7F;
      req[3] = 7'h7F;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 4; i++) last_seg[i] = 7'hxx;
      scan_edges(8, 8);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (last_seg[d] !== req[d]) begin
          failures++;
          $display("FAIL blank_lz value=%h digit%0d got seg=%h required %h",
                   value, d, last_seg[d], req[d]);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_load_mid();
    int guard;
    bit hit;
    value = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    scan_edges(8, 8);
    guard = 0;
    while (digit_sel != 2'd1 && guard < 8) begin
      scan_edges(1, 8);
      guard++;
    end
    value = 16'hAAAA;
    load = 1'b1;
    step();
    load = 1'b0;
    guard = 0;
    while (digit_sel != 2'd3 && guard < 8) begin
      scan_edges(1, 8);
      guard++;
    end
    checks++;
    if (digit_sel !== 2'd3 || seg !== 7'h79) begin
      failures++;
      $display("FAIL load_mid_old got sel=%0d seg=%h required sel=3 seg=79", digit_sel, seg);
    end
    scan_edges(1, 8);
    checks++;
    if (digit_sel !== 2'd0 || seg !== 7'h08) begin
      failures++;
      $display("FAIL load_mid_new got sel=%0d seg=%h required sel=0 seg=08", digit_sel, seg);
    end
    guard = 0;
    while (digit_sel != 2'd3 && guard < 8) begin
      scan_edges(1, 8);
      guard++;
    end
    scan_clk = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      if (wrap_next()) begin
        value = 16'h5678;
        load = 1'b1;
        step();
        load = 1'b0;
        hit = 1'b1;
        checks++;
        if (digit_sel !== 2'd0 || seg !== 7'h00) begin
          failures++;
          $display("FAIL load_on_wrap got sel=%0d seg=%h required sel=0 seg=00", digit_sel, seg);
        end
      end else begin
        step();
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL load_on_wrap_timeout got no wrap tick required one within 12 clocks");
    end
    scan_clk = 1'b0;
    for (int i = 0; i < 4; i++) last_seg[i] = 7'hxx;
    scan_edges(4, 8);
    checks++;
    if (last_seg[0] !== 7'h00) begin
      failures++;
      $display("FAIL load_on_wrap_shadow got seg=%h required 00", last_seg[0]);
    end
  endtask

  task automatic test_glitch();
    int t, w, rises, changes;
    logic prev;
    logic [1:0] psel;
    scan_clk = 1'b0;
    for (int i = 0; i < 6; i++) step();
    prev = samp_edge;
    psel = digit_sel;
    rises = 0;
    changes = 0;
    for (int it = 0; it < 30; it++) begin
      t = $urandom_range(1, 14);
      w = $urandom_range(1, 17);
      if (1 + t + w == 20 || 1 + t + w == 21) w += 2;
      fork
        begin
          #(t) scan_clk = 1'b1;
          #(w) scan_clk = 1'b0;
        end
        begin
          for (int k = 0; k < 2; k++) begin
            step();
            if (samp_edge && !prev) rises++;
            prev = samp_edge;
            if (digit_sel != psel) changes++;
            psel = digit_sel;
          end
        end
      join
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (digit_sel != psel) changes++;
      psel = digit_sel;
    end
    checks++;
    if (changes != rises) begin
      failures++;
      $display("FAIL glitch_ticks got %0d digit advances required %0d", changes, rises);
    end
  endtask

  task automatic test_random();
    int half_left;
    logic [15:0] mask;
    half_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (half_left == 0) begin
        scan_clk = ~scan_clk;
        half_left = $urandom_range(1, 10);
      end
      half_left--;
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        case ($urandom_range(0, 4))
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          3: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        value = 16'($urandom) & mask;
        dp_in = 4'($urandom);
      end
      blank_lz = 1'($urandom_range(0, 1));
      step();
    end
    load = 1'b0;
    scan_clk = 1'b0;
  endtask

  task automatic test_reset_mid();
    scan_edges(2, 8);
    scan_clk = 1'b1;
    step();
    #5 clear = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, digit_sel} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid got an=%b seg=%h dp=%b sel=%0d required an=1111 seg=7f dp=1 sel=0",
               an, seg, dp, digit_sel);
    end
    scan_clk = 1'b0;
    step();
    #2 clear = 1'b0;
    step();
    checks++;
    if (an !== 4'hE || seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset_release got an=%b seg=%h required an=1110 seg=7f", an, seg);
    end
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_1234();
    test_latency();
    test_blank_lz();
    test_load_mid();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
